// File: rtl/ntt_job_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ntt_job_sequencer_if
// Desc     : Command, BRAM-port and NTT-core signals of the job sequencer
// Revision : 1.0
// ============================================================================
interface ntt_job_sequencer_if #(
  parameter int N = 64
);
  localparam int IW = $clog2(N);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [10:0]   cmd_src;
  logic [10:0]   cmd_dst;
  logic          busy;
  logic          job_done;
  logic          job_err;

  logic [12:0]   bram_addr;
  logic          bram_en;
  logic          bram_we;
  logic [63:0]   bram_din;
  logic [63:0]   bram_dout;

  logic          coef_we;
  logic [IW-1:0] coef_idx;
  logic [63:0]   coef_data;
  logic          ntt_rst;
  logic          ntt_done;
  logic [IW-1:0] res_idx;
  logic [63:0]   res_data;

  modport master (
    input  cmd_valid, cmd_src, cmd_dst, bram_dout, ntt_done, res_data,
    output cmd_ready, busy, job_done, job_err,
    output bram_addr, bram_en, bram_we, bram_din,
    output coef_we, coef_idx, coef_data, ntt_rst, res_idx
  );

  modport slave (
    output cmd_valid, cmd_src, cmd_dst, bram_dout, ntt_done, res_data,
    input  cmd_ready, busy, job_done, job_err,
    input  bram_addr, bram_en, bram_we, bram_din,
    input  coef_we, coef_idx, coef_data, ntt_rst, res_idx
  );
endinterface
`default_nettype wire

// File: rtl/ntt_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ntt_job_sequencer
// Desc     : Loads N coefficients from BRAM, runs the NTT core, stores N results
// Revision : 1.0
// ============================================================================
module ntt_job_sequencer #(
  parameter int N          = 64,
  parameter int RD_LAT     = 1,
  parameter int ADDR_SHIFT = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  ntt_job_sequencer_if.master bus
);

  localparam int            IW     = $clog2(N);
  localparam int            CW     = $clog2(TIMEOUT + 1);
  localparam logic [IW:0]   C_N    = (IW+1)'(N);
  localparam logic [IW-1:0] C_LAST = IW'(N - 1);
  localparam logic [CW-1:0] C_TMO  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_KICK  = 3'd2,
    S_WAIT  = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [10:0]   src_q, src_d;
  logic [10:0]   dst_q, dst_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [12:0]   addr_q, addr_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [63:0]   din_q, din_d;
  logic [IW-1:0] res_idx_q, res_idx_d;

  // Read-return delay line: stage 0 tracks the read currently on the BRAM pins,
  // stage RD_LAT lines up with its data on bram_dout.
  logic [RD_LAT:0] rv_q;
  logic [IW-1:0]   ridx_q [RD_LAT+1];
  logic            rv0_d;
  logic [IW-1:0]   ridx0_d;
  logic            last_capture;

  function automatic logic [12:0] word_addr(input logic [10:0] base, input logic [IW:0] idx);
    logic [10:0] w;
    w = base + 11'(idx);
    return 13'(32'(w) << ADDR_SHIFT);
  endfunction

  assign last_capture = rv_q[RD_LAT] && (ridx_q[RD_LAT] == C_LAST);

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    addr_d    = addr_q;
    en_d      = 1'b0;
    we_d      = 1'b0;
    din_d     = din_q;
    res_idx_d = res_idx_q;
    rv0_d     = 1'b0;
    ridx0_d   = ridx_q[0];
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          src_d     = bus.cmd_src;
          dst_d     = bus.cmd_dst;
          err_d     = 1'b0;
          tmo_d     = '0;
          res_idx_d = '0;
          addr_d    = word_addr(bus.cmd_src, '0);
          en_d      = 1'b1;
          rv0_d     = 1'b1;
          ridx0_d   = '0;
          cnt_d     = (IW+1)'(1);
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q < C_N) begin
          addr_d  = word_addr(src_q, cnt_q);
          en_d    = 1'b1;
          rv0_d   = 1'b1;
          ridx0_d = cnt_q[IW-1:0];
          cnt_d   = cnt_q + 1'b1;
        end
        if (last_capture) begin
          state_d = S_KICK;
        end
      end
      S_KICK: begin
        tmo_d   = '0;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Write 0 is staged here so that STORE shows exactly N write cycles.
        if (bus.ntt_done) begin
          addr_d    = word_addr(dst_q, '0);
          din_d     = bus.res_data;
          en_d      = 1'b1;
          we_d      = 1'b1;
          res_idx_d = res_idx_q + 1'b1;
          cnt_d     = (IW+1)'(1);
          state_d   = S_STORE;
        end else if (tmo_q == C_TMO) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_STORE: begin
        if (cnt_q < C_N) begin
          addr_d    = word_addr(dst_q, cnt_q);
          din_d     = bus.res_data;
          en_d      = 1'b1;
          we_d      = 1'b1;
          res_idx_d = res_idx_q + 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end else begin
          res_idx_d = '0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      din_q     <= '0;
      res_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      we_q      <= we_d;
      din_q     <= din_d;
      res_idx_q <= res_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q <= '0;
      for (int s = 0; s <= RD_LAT; s++) begin
        ridx_q[s] <= '0;
      end
    end else begin
      rv_q      <= {rv_q[RD_LAT-1:0], rv0_d};
      ridx_q[0] <= ridx0_d;
      for (int s = 1; s <= RD_LAT; s++) begin
        ridx_q[s] <= ridx_q[s-1];
      end
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.job_done  = (state_q == S_DONE);
  assign bus.job_err   = (state_q == S_DONE) && err_q;
  assign bus.ntt_rst   = !((state_q == S_WAIT) || (state_q == S_STORE));
  assign bus.bram_addr = addr_q;
  assign bus.bram_en   = en_q;
  assign bus.bram_we   = we_q;
  assign bus.bram_din  = din_q;
  assign bus.coef_we   = rv_q[RD_LAT];
  assign bus.coef_idx  = ridx_q[RD_LAT];
  assign bus.coef_data = rv_q[RD_LAT] ? bus.bram_dout : 64'd0;
  assign bus.res_idx   = res_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_ntt_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_job_sequencer
// Desc     : Directed bench: dut_a (N=64, RD_LAT=1) and dut_b (N=64, RD_LAT=3)
// Revision : 1.0
// ============================================================================
module tb_ntt_job_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ntt_job_sequencer_if #(.N(64)) bus_a ();
  ntt_job_sequencer_if #(.N(64)) bus_b ();

  ntt_job_sequencer #(.N(64), .RD_LAT(1), .ADDR_SHIFT(2), .TIMEOUT(100)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  ntt_job_sequencer #(.N(64), .RD_LAT(3), .ADDR_SHIFT(2), .TIMEOUT(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  int n_assert = 0;
  int n_fail   = 0;
  int done_dly = 20;
  logic ntt_never = 1'b0;

  function automatic logic [63:0] bram_word(input logic [10:0] k);
    return {32'hC0FF_EE00 ^ 32'(k), 32'(k)};
  endfunction
  function automatic logic [63:0] res_word(input int j);
    return 64'hD00D_0000_0000_0000 | 64'(j * 257);
  endfunction
  function automatic logic [12:0] exp_addr(input logic [10:0] base, input int i);
    logic [10:0] w;
    w = base + 11'(i);
    return {w, 2'b00};
  endfunction

  // BRAM models (word k holds bram_word(k)) and NTT core models
  logic [63:0] pa0, pb0, pb1, pb2;
  int ncnt_a = 0, ncnt_b = 0;
  always @(posedge clk) begin
    pa0 <= bram_word(bus_a.bram_addr[12:2]);
    pb0 <= bram_word(bus_b.bram_addr[12:2]);
    pb1 <= pb0;
    pb2 <= pb1;
    ncnt_a <= bus_a.ntt_rst ? 0 : ncnt_a + 1;
    ncnt_b <= bus_b.ntt_rst ? 0 : ncnt_b + 1;
  end
  assign bus_a.bram_dout = pa0;
  assign bus_b.bram_dout = pb2;
  assign bus_a.ntt_done  = !bus_a.ntt_rst && !ntt_never && (ncnt_a >= done_dly - 1);
  assign bus_b.ntt_done  = !bus_b.ntt_rst && !ntt_never && (ncnt_b >= done_dly - 1);
  assign bus_a.res_data  = res_word(int'(bus_a.res_idx));
  assign bus_b.res_data  = res_word(int'(bus_b.res_idx));

  int gcyc = 0;
  int m_cyc[2], m_coef_cnt[2], m_coef_bad[2], m_last_coef[2];
  int m_rd_cnt[2], m_rd_bad[2], m_wr_cnt[2], m_wr_bad[2];
  int m_done_cnt[2], m_done_cyc[2], m_done_g[2], m_err_cnt[2], m_err_alone[2];
  int m_acc_total[2], m_acc_gap[2], m_rb_bad[2], m_we_bad[2];
  logic [12:0] m_rd_first[2], m_rd_at8[2], m_wr_first[2], m_wr_last[2];
  logic [10:0] m_src[2], m_dst[2];

  task automatic mon(input int d, input logic v, rdy, bsy, dn, er, en, we,
                     input logic [12:0] addr, input logic [63:0] din,
                     input logic cwe, input logic [5:0] cidx, input logic [63:0] cdata,
                     input logic nrst, input logic [10:0] csrc, cdst);
    m_cyc[d]++;
    if (rdy == bsy) m_rb_bad[d]++;
    if (we && nrst) m_we_bad[d]++;
    if (cwe) begin
      if (cidx != 6'(m_coef_cnt[d]) || cdata != bram_word(m_src[d] + 11'(m_coef_cnt[d])))
        m_coef_bad[d]++;
      m_coef_cnt[d]++;
      m_last_coef[d] = m_cyc[d];
    end
    if (en && !we) begin
      if (addr != exp_addr(m_src[d], m_rd_cnt[d])) m_rd_bad[d]++;
      if (m_rd_cnt[d] == 0) m_rd_first[d] = addr;
      if (m_rd_cnt[d] == 8) m_rd_at8[d] = addr;
      m_rd_cnt[d]++;
    end
    if (en && we) begin
      if (addr != exp_addr(m_dst[d], m_wr_cnt[d]) || din != res_word(m_wr_cnt[d])) m_wr_bad[d]++;
      if (m_wr_cnt[d] == 0) m_wr_first[d] = addr;
      m_wr_last[d] = addr;
      m_wr_cnt[d]++;
    end
    if (dn) begin
      m_done_cnt[d]++;
      m_done_cyc[d] = m_cyc[d];
      m_done_g[d]   = gcyc;
      if (er) m_err_cnt[d]++;
    end
    if (er && !dn) m_err_alone[d]++;
    if (v && rdy) begin
      m_acc_total[d]++;
      m_acc_gap[d]  = gcyc - m_done_g[d];
      m_src[d]      = csrc;
      m_dst[d]      = cdst;
      m_cyc[d]      = 1;
      m_coef_cnt[d] = 0; m_coef_bad[d] = 0; m_last_coef[d] = 0;
      m_rd_cnt[d]   = 0; m_rd_bad[d]   = 0; m_wr_cnt[d]    = 0; m_wr_bad[d] = 0;
      m_done_cnt[d] = 0; m_done_cyc[d] = 0; m_err_cnt[d]   = 0;
    end
  endtask

  always @(negedge clk) begin
    gcyc++;
    mon(0, bus_a.cmd_valid, bus_a.cmd_ready, bus_a.busy, bus_a.job_done, bus_a.job_err,
        bus_a.bram_en, bus_a.bram_we, bus_a.bram_addr, bus_a.bram_din, bus_a.coef_we,
        bus_a.coef_idx, bus_a.coef_data, bus_a.ntt_rst, bus_a.cmd_src, bus_a.cmd_dst);
    mon(1, bus_b.cmd_valid, bus_b.cmd_ready, bus_b.busy, bus_b.job_done, bus_b.job_err,
        bus_b.bram_en, bus_b.bram_we, bus_b.bram_addr, bus_b.bram_din, bus_b.coef_we,
        bus_b.coef_idx, bus_b.coef_data, bus_b.ntt_rst, bus_b.cmd_src, bus_b.cmd_dst);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int d, input int src, input int dst);
    @(posedge clk); #1;
    if (d == 0) begin bus_a.cmd_valid = 1'b1; bus_a.cmd_src = 11'(src); bus_a.cmd_dst = 11'(dst); end
    else        begin bus_b.cmd_valid = 1'b1; bus_b.cmd_src = 11'(src); bus_b.cmd_dst = 11'(dst); end
    @(posedge clk); #1;
    bus_a.cmd_valid = 1'b0;
    bus_b.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d, input string tag);
    for (int i = 0; i < 500 && m_done_cnt[d] == 0; i++) begin
      @(negedge clk); #1;
    end
    chk(tag, 64'(m_done_cnt[d] != 0), 64'd1);
  endtask

  int acc0;
  logic [10:0] cur_src;

  initial begin
    rst_n = 1'b0;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_src = '0; bus_a.cmd_dst = '0;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_src = '0; bus_b.cmd_dst = '0;
    repeat (3) @(posedge clk); #1;

    chk("rst_cmd_ready", 64'(bus_a.cmd_ready), 64'd1);
    chk("rst_busy",      64'(bus_a.busy),      64'd0);
    chk("rst_ntt_rst",   64'(bus_a.ntt_rst),   64'd1);
    chk("rst_bram_en",   64'(bus_a.bram_en),   64'd0);
    chk("rst_bram_addr", 64'(bus_a.bram_addr), 64'd0);
    chk("rst_coef_we",   64'(bus_b.coef_we),   64'd0);
    chk("rst_job_done",  64'(bus_b.job_done),  64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Basic job: src=0, dst=64, NTT done after 20 WAIT cycles
    done_dly = 20;
    start(0, 0, 64);
    wait_done(0, "t2_done_seen");
    chk("t2_coef_cnt",   64'(m_coef_cnt[0]),  64'd64);
    chk("t2_coef_bad",   64'(m_coef_bad[0]),  64'd0);
    chk("t2_last_coef",  64'(m_last_coef[0]), 64'd66);
    chk("t2_rd_cnt",     64'(m_rd_cnt[0]),    64'd64);
    chk("t2_rd_bad",     64'(m_rd_bad[0]),    64'd0);
    chk("t2_wr_cnt",     64'(m_wr_cnt[0]),    64'd64);
    chk("t2_wr_bad",     64'(m_wr_bad[0]),    64'd0);
    chk("t2_wr_first",   64'(m_wr_first[0]),  64'h100);
    chk("t2_wr_last",    64'(m_wr_last[0]),   64'h1FC);
    chk("t2_done_cyc",   64'(m_done_cyc[0]),  64'd152);
    chk("t2_err",        64'(m_err_cnt[0]),   64'd0);
    @(negedge clk); #1;
    chk("t2_idle_ntt_rst", 64'(bus_a.ntt_rst), 64'd1);
    chk("t2_idle_busy",    64'(bus_a.busy),    64'd0);

    // Reset during STORE after the tenth write
    start(0, 5, 100);
    for (int i = 0; i < 500 && m_wr_cnt[0] < 10; i++) begin
      @(negedge clk); #1;
    end
    chk("t1_reached_store", 64'(m_wr_cnt[0]), 64'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_we",      64'(bus_a.bram_we),   64'd0);
    chk("t1_en",      64'(bus_a.bram_en),   64'd0);
    chk("t1_addr",    64'(bus_a.bram_addr), 64'd0);
    chk("t1_din",     bus_a.bram_din,       64'd0);
    chk("t1_res_idx", 64'(bus_a.res_idx),   64'd0);
    chk("t1_ntt_rst", 64'(bus_a.ntt_rst),   64'd1);
    chk("t1_busy",    64'(bus_a.busy),      64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk); #1;
    chk("t1_no_done",   64'(m_done_cnt[0]), 64'd0);
    chk("t1_no_writes", 64'(m_wr_cnt[0]),   64'd10);
    start(0, 7, 300);
    wait_done(0, "t1_rerun_done_seen");
    chk("t1_rerun_coef_bad", 64'(m_coef_bad[0]), 64'd0);
    chk("t1_rerun_wr_cnt",   64'(m_wr_cnt[0]),   64'd64);
    chk("t1_rerun_wr_bad",   64'(m_wr_bad[0]),   64'd0);
    chk("t1_rerun_done_cyc", 64'(m_done_cyc[0]), 64'd152);

    // RD_LAT=3 load sweep
    done_dly = 5;
    start(1, 100, 0);
    wait_done(1, "t3_done_seen");
    chk("t3_coef_cnt",  64'(m_coef_cnt[1]),  64'd64);
    chk("t3_coef_bad",  64'(m_coef_bad[1]),  64'd0);
    chk("t3_last_coef", 64'(m_last_coef[1]), 64'd68);
    chk("t3_wr_bad",    64'(m_wr_bad[1]),    64'd0);
    chk("t3_done_cyc",  64'(m_done_cyc[1]),  64'd139);

    // Timeout abort: ntt_done never rises
    ntt_never = 1'b1;
    start(1, 0, 0);
    wait_done(1, "t4_done_seen");
    chk("t4_err_with_done", 64'(m_err_cnt[1]),   64'd1);
    chk("t4_err_alone",     64'(m_err_alone[1]), 64'd0);
    chk("t4_done_cyc",      64'(m_done_cyc[1]),  64'd170);
    chk("t4_wr_cnt",        64'(m_wr_cnt[1]),    64'd0);
    chk("t4_we_bad",        64'(m_we_bad[1]),    64'd0);
    repeat (2) @(negedge clk); #1;
    chk("t4_ntt_rst_after", 64'(bus_b.ntt_rst),  64'd1);
    ntt_never = 1'b0;

    // cmd_valid held with alternating src throughout a job
    done_dly = 4;
    acc0 = m_acc_total[0];
    cur_src = 11'd10;
    @(posedge clk); #1;
    bus_a.cmd_valid = 1'b1; bus_a.cmd_src = cur_src; bus_a.cmd_dst = 11'd500;
    @(negedge clk); #1;
    for (int i = 0; i < 500 && m_done_cnt[0] == 0; i++) begin
      @(posedge clk); #1;
      cur_src = (cur_src == 11'd10) ? 11'd20 : 11'd10;
      bus_a.cmd_src = cur_src;
      @(negedge clk); #1;
    end
    chk("t5_first_done",  64'(m_done_cnt[0]),  64'd1);
    chk("t5_first_src",   64'(m_src[0]),       64'd10);
    chk("t5_first_coef",  64'(m_coef_bad[0]),  64'd0);
    chk("t5_single_acc",  64'(m_acc_total[0] - acc0), 64'd1);
    @(negedge clk); #1;
    chk("t5_reaccept_gap", 64'(m_acc_gap[0]), 64'd1);
    chk("t5_second_acc",   64'(m_acc_total[0] - acc0), 64'd2);
    @(posedge clk); #1;
    bus_a.cmd_valid = 1'b0;
    wait_done(0, "t5_second_done_seen");
    chk("t5_second_coef", 64'(m_coef_bad[0]), 64'd0);
    chk("t5_second_wr",   64'(m_wr_bad[0]),   64'd0);
    chk("t5_ready_busy",  64'(m_rb_bad[0]),   64'd0);

    // Address wrap at the top of the 11-bit word space
    done_dly = 3;
    start(1, 2040, 2030);
    wait_done(1, "t6_done_seen");
    chk("t6_rd_first", 64'(m_rd_first[1]), 64'h1FE0);
    chk("t6_rd_at8",   64'(m_rd_at8[1]),   64'h0);
    chk("t6_rd_bad",   64'(m_rd_bad[1]),   64'd0);
    chk("t6_coef_bad", 64'(m_coef_bad[1]), 64'd0);
    chk("t6_wr_first", 64'(m_wr_first[1]), 64'h1FB8);
    chk("t6_wr_bad",   64'(m_wr_bad[1]),   64'd0);
    chk("t6_we_bad",   64'(m_we_bad[0] + m_we_bad[1]), 64'd0);
    chk("t6_rb_bad",   64'(m_rb_bad[1]),   64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
